pop_count_checker: RTL
======================

Name: pop_count_checker

Overview:
Synthesizable initiator and checker for the sequential popcount unit's start/done handshake. It sweeps a range of input vectors and issues a one-cycle start pulse for each. It then waits for done, compares the returned count against an internally computed popcount, and tallies pass/fail results. It sits beside the popcount unit on the board as a hardware self-test, so no simulator is needed.

Parameters:
WIDTH, 10, bit width of input vectors and dut_input_number
COUNT_W, 8, width of the count returned by the unit under test
CNT_W, 11, width of pass/fail tally counters
FIRST_VEC, 0, first vector in the sweep
LAST_VEC, 1023, last vector in the sweep (inclusive; FIRST_VEC <= LAST_VEC)
TIMEOUT, 64, max cycles to wait for done after start deasserts
GAP, 2, idle cycles between consecutive vectors

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
run  input  1  begin a sweep; sampled only in IDLE or FINISH
dut_start  output  1  one-cycle start pulse to unit under test
dut_input_number  output  WIDTH  vector presented to unit under test
dut_count  input  COUNT_W  result from unit under test
dut_done  input  1  completion flag from unit under test
busy  output  1  sweep in progress
finished  output  1  sweep complete; held until next run or rst
all_pass  output  1  finished with fail_count==0
pass_count  output  CNT_W  vectors matching expected
fail_count  output  CNT_W  mismatches plus timeouts
timeout_flag  output  1  sticky; at least one vector timed out this sweep
first_fail_valid  output  1  sticky; first_fail_vec is meaningful
first_fail_vec  output  WIDTH  vector of first failure in sweep

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides everything, including mid-sweep.
- Reset values: every output is 0. State returns to IDLE and internal counters are cleared.
- States: IDLE, SETUP, PULSE, WAIT, SETTLE, CHECK, GAP_ST, FINISH.
- IDLE:
  - busy=0.
  - run=1 → SETUP. pass_count, fail_count, timeout_flag, first_fail_valid, first_fail_vec, finished and all_pass are cleared, and vec is loaded with FIRST_VEC.
- SETUP (1 cycle):
  - busy=1. dut_input_number<=vec.
  - dut_input_number stays stable from here through CHECK.
- PULSE (1 cycle):
  - dut_start=1. dut_start is 0 in every other state.
  - → WAIT, timer cleared.
- WAIT:
  - done_q registers dut_done every cycle in every state.
  - Completion is a rising edge: dut_done=1 && done_q=0 → SETTLE.
  - A done level held high from the previous vector is therefore not accepted.
  - The timer increments each WAIT cycle. Reaching TIMEOUT with no edge: fail_count+1, timeout_flag<=1, first-fail capture applies → GAP_ST.
- SETTLE (1 cycle): lets count settle → CHECK.
- CHECK (1 cycle):
  - expected = popcount(dut_input_number), zero-extended to COUNT_W.
  - dut_count==expected → pass_count+1. Otherwise fail_count+1 and first-fail capture applies.
  - → GAP_ST.
- First-fail capture: if first_fail_valid==0, then first_fail_vec<=vec and first_fail_valid<=1.
- GAP_ST:
  - Waits exactly GAP cycles.
  - If vec==LAST_VEC → FINISH. Otherwise vec+1 → SETUP.
  - vec never wraps past LAST_VEC.
- FINISH:
  - busy=0, finished=1, all_pass=(fail_count==0). These hold.
  - run=1 → restart exactly as from IDLE.
- Other rules:
  - run is ignored while busy.
  - Tally counters saturate at 2^CNT_W−1.
  - Latency per vector with a DUT done edge L cycles after start deasserts: 1 (SETUP) + 1 (PULSE) + L + 1 (SETTLE) + 1 (CHECK) + GAP.
  - dut_done or dut_count activity outside WAIT/CHECK is ignored.

Test Plan:
1. Correct behavioural popcount model (done edge 12 cycles after start), FIRST_VEC=0, LAST_VEC=15, run pulse → finished=1, pass_count=16, fail_count=0, all_pass=1, first_fail_valid=0.
2. Model returns count+1 for input 5 only, range 0..15 → pass_count=15, fail_count=1, first_fail_vec=5, first_fail_valid=1, all_pass=0.
3. Model never raises done for input 3, TIMEOUT=8, range 0..7 → timeout_flag=1, fail_count=1, pass_count=7, first_fail_vec=3, sweep completes.
4. Model holds done high until next start; check dut_start is exactly one cycle wide per vector and the done level is not double-counted → range 0..7 gives pass_count=8.
5. Assert rst for one cycle while in WAIT mid-sweep → next cycle all outputs 0, dut_start 0, state IDLE. A new run restarts from FIRST_VEC with cleared tallies.
6. Pulse run while busy → ignored, tallies unaffected. Pulse run in FINISH → counters clear and the sweep reruns to the same result. Default range 0..1023 with the correct model → pass_count=1024.

Source files
------------

// File: rtl/pop_count_if.sv
// Start/done handshake between the self-test checker and the popcount unit.
// The checker drives start and the vector; the unit returns count and done.
interface pop_count_if #(
    parameter int WIDTH   = 10,
    parameter int COUNT_W = 8
);
    logic               dut_start;
    logic [WIDTH-1:0]   dut_input_number;
    logic [COUNT_W-1:0] dut_count;
    logic               dut_done;

    modport master (
        output dut_start,
        output dut_input_number,
        input  dut_count,
        input  dut_done
    );

    modport slave (
        input  dut_start,
        input  dut_input_number,
        output dut_count,
        output dut_done
    );
endinterface

// File: rtl/pop_count_checker.sv
// Hardware self-test for the sequential popcount unit: sweeps a vector range,
// pulses start for each vector, waits for a done edge and tallies results.
module pop_count_checker #(
    parameter int WIDTH     = 10,
    parameter int COUNT_W   = 8,
    parameter int CNT_W     = 11,
    parameter int FIRST_VEC = 0,
    parameter int LAST_VEC  = 1023,
    parameter int TIMEOUT   = 64,
    parameter int GAP       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    pop_count_if.master        pc,
    output logic               busy,
    output logic               finished,
    output logic               all_pass,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   fail_count,
    output logic               timeout_flag,
    output logic               first_fail_valid,
    output logic [WIDTH-1:0]   first_fail_vec
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 2);

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, WAIT, SETTLE, CHECK, GAP_ST, FINISH
    } state_t;

    function automatic logic [COUNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + COUNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [WIDTH-1:0]   dinum_q, dinum_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               done_q;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               tflag_q, tflag_d;
    logic               ffv_q, ffv_d;
    logic [WIDTH-1:0]   ffvec_q, ffvec_d;
    logic               fin_q, fin_d;
    logic               allp_q, allp_d;
    logic               record_fail;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dinum_d     = dinum_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tflag_d     = tflag_q;
        ffv_d       = ffv_q;
        ffvec_d     = ffvec_q;
        fin_d       = fin_q;
        allp_d      = allp_q;
        record_fail = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                if (run) begin
                    state_d = SETUP;
                    vec_d   = WIDTH'(FIRST_VEC);
                    pass_d  = '0;
                    fail_d  = '0;
                    tflag_d = 1'b0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    fin_d   = 1'b0;
                    allp_d  = 1'b0;
                end
            end
            SETUP: begin
                dinum_d = vec_q;
                state_d = PULSE;
            end
            PULSE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge counts, so a done level left over
                // from the previous vector cannot complete this one.
                if (pc.dut_done && !done_q) begin
                    state_d = SETTLE;
                end else if (int'(timer_q) + 1 >= TIMEOUT) begin
                    tflag_d     = 1'b1;
                    record_fail = 1'b1;
                    gap_d       = '0;
                    state_d     = GAP_ST;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            SETTLE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (pc.dut_count == popcount(dinum_q)) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    record_fail = 1'b1;
                end
                gap_d   = '0;
                state_d = GAP_ST;
            end
            GAP_ST: begin
                if (int'(gap_q) + 1 >= GAP) begin
                    if (vec_q == WIDTH'(LAST_VEC)) begin
                        fin_d   = 1'b1;
                        allp_d  = (fail_q == '0);
                        state_d = FINISH;
                    end else begin
                        vec_d   = vec_q + WIDTH'(1);
                        state_d = SETUP;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (record_fail) begin
            fail_d = sat_inc(fail_q);
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = vec_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            dinum_q <= '0;
            timer_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            tflag_q <= 1'b0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            fin_q   <= 1'b0;
            allp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dinum_q <= dinum_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            done_q  <= pc.dut_done;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tflag_q <= tflag_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            fin_q   <= fin_d;
            allp_q  <= allp_d;
        end
    end

    assign pc.dut_start        = (state_q == PULSE);
    assign pc.dut_input_number = dinum_q;
    assign busy                = (state_q != IDLE) && (state_q != FINISH);
    assign finished            = fin_q;
    assign all_pass            = allp_q;
    assign pass_count          = pass_q;
    assign fail_count          = fail_q;
    assign timeout_flag        = tflag_q;
    assign first_fail_valid    = ffv_q;
    assign first_fail_vec      = ffvec_q;

endmodule
